oam_dma_arbiter: RTL and testbench

Arbitrates the CPU memory-unit bus against a GameBoy OAM DMA engine. A CPU write to the DMA register launches a 160-byte copy from page XX00–XX9F to OAM FE00–FE9F. During the copy the DMA engine owns the main bus. The CPU keeps access only to high RAM (FF80–FFFE) and to the DMA register. The block sits between the datapath's memory interface and the memory unit.

---
 rtl/oam_dma_arbiter_pkg.sv | 26 ++
 rtl/oam_dma_arbiter_if.sv | 39 +++
 rtl/oam_dma_arbiter_dma_sequencer.sv | 89 ++++++++
 rtl/oam_dma_arbiter.sv | 101 ++++++++++
 tb/tb_oam_dma_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/oam_dma_arbiter_pkg.sv
// Shared types, bus address constants and source-page mapping for the OAM DMA arbiter.
// Optional build macro DMA_ECHO_MAP_EN folds echo-RAM source pages E0-FF down onto C0-DF.
package oam_dma_arbiter_pkg;

   typedef enum logic [1:0] {
      DMA_IDLE  = 2'd0,
      DMA_START = 2'd1,
      DMA_XFER  = 2'd2
   } dma_state_t;

   localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
   localparam logic [15:0] OAM_BASE     = 16'hFE00;
   localparam logic [15:0] HRAM_LO      = 16'hFF80;
   localparam logic [15:0] HRAM_HI      = 16'hFFFE;
   localparam logic [7:0]  OPEN_BUS     = 8'hFF;

   // Page actually driven onto the bus; register readback always uses the written value.
   function automatic logic [7:0] source_page(input logic [7:0] page);
`ifdef DMA_ECHO_MAP_EN
      return (page >= 8'hE0) ? (page - 8'h20) : page;
`else
      return page;
`endif
   endfunction

endpackage

// File: rtl/oam_dma_arbiter_if.sv
// CPU-side, main-bus and high-RAM signal bundle of the OAM DMA arbiter.
interface oam_dma_arbiter_if;

   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_re;
   logic        cpu_we;
   logic [7:0]  cpu_rdata;

   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_re;
   logic        mem_we;
   logic [7:0]  mem_rdata;

   logic [6:0]  hi_addr;
   logic [7:0]  hi_wdata;
   logic        hi_re;
   logic        hi_we;
   logic [7:0]  hi_rdata;

   logic        dma_active;
   logic        dma_done;

   // Arbiter side.
   modport slave (
      input  cpu_addr, cpu_wdata, cpu_re, cpu_we, mem_rdata, hi_rdata,
      output cpu_rdata, mem_addr, mem_wdata, mem_re, mem_we,
             hi_addr, hi_wdata, hi_re, hi_we, dma_active, dma_done
   );

   // CPU datapath plus memory units surrounding the arbiter.
   modport master (
      output cpu_addr, cpu_wdata, cpu_re, cpu_we, mem_rdata, hi_rdata,
      input  cpu_rdata, mem_addr, mem_wdata, mem_re, mem_we,
             hi_addr, hi_wdata, hi_re, hi_we, dma_active, dma_done
   );

endinterface

// File: rtl/oam_dma_arbiter_dma_sequencer.sv
// DMA sequencer: one M-cycle startup, byte-slot and phase counters, completion pulse.
module dma_sequencer
   import oam_dma_arbiter_pkg::*;
#(
   parameter  int DMA_LEN         = 160,
   parameter  int CYCLES_PER_BYTE = 4,
   localparam int PH_W            = $clog2(CYCLES_PER_BYTE)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            trigger_i,
   output dma_state_t      state_o,
   output logic [7:0]      slot_o,
   output logic [PH_W-1:0] phase_o,
   output logic            done_o
);

   localparam logic [PH_W-1:0] PH_LAST   = PH_W'(CYCLES_PER_BYTE - 1);
   localparam logic [7:0]      SLOT_LAST = 8'(DMA_LEN - 1);

   dma_state_t      state_q, state_d;
   logic [7:0]      slot_q, slot_d;
   logic [PH_W-1:0] phase_q, phase_d;
   logic            done_q, done_d;

   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d = state_q;
      slot_d  = slot_q;
      phase_d = phase_q;
      done_d  = 1'b0;

      unique case (state_q)
         DMA_IDLE: ;
         DMA_START: begin
            if (phase_q == PH_LAST) begin
               state_d = DMA_XFER;
               phase_d = '0;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         DMA_XFER: begin
            if (phase_q == PH_LAST) begin
               phase_d = '0;
               if (slot_q == SLOT_LAST) begin
                  state_d = DMA_IDLE;
                  slot_d  = '0;
                  done_d  = 1'b1;
               end else begin
                  slot_d = slot_q + 8'd1;
               end
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         default: state_d = DMA_IDLE;
      endcase

      // A register write restarts from any state and outranks completion.
      if (trigger_i) begin
         state_d = DMA_START;
         slot_d  = '0;
         phase_d = '0;
         done_d  = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= DMA_IDLE;
         slot_q  <= '0;
         phase_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         phase_q <= phase_d;
         done_q  <= done_d;
      end
   end

   assign state_o = state_q;
   assign slot_o  = slot_q;
   assign phase_o = phase_q;
   assign done_o  = done_q;

endmodule

// File: rtl/oam_dma_arbiter.sv
// OAM DMA arbiter top: CPU address decode, main-bus/high-RAM muxes, page register and data latch.
// Build macro DMA_ECHO_MAP_EN (see package) selects echo-page folding of the source address.
module oam_dma_arbiter
   import oam_dma_arbiter_pkg::*;
#(
   parameter int DMA_LEN         = 160,
   parameter int CYCLES_PER_BYTE = 4
) (
   input  logic              clk,
   input  logic              rst,
   oam_dma_arbiter_if.slave  bus
);

   localparam int PH_W = $clog2(CYCLES_PER_BYTE);

   dma_state_t      state;
   logic [7:0]      slot;
   logic [PH_W-1:0] phase;
   logic            done;

   logic [7:0] page_q, page_d;
   logic [7:0] latch_q, latch_d;
   logic       reg_hit, hram_hit, trigger;

   assign reg_hit  = (bus.cpu_addr == DMA_REG_ADDR);
   assign hram_hit = (bus.cpu_addr >= HRAM_LO) && (bus.cpu_addr <= HRAM_HI);
   assign trigger  = bus.cpu_we && reg_hit;

   dma_sequencer #(
      .DMA_LEN         (DMA_LEN),
      .CYCLES_PER_BYTE (CYCLES_PER_BYTE)
   ) u_seq (
      .clk       (clk),
      .rst       (rst),
      .trigger_i (trigger),
      .state_o   (state),
      .slot_o    (slot),
      .phase_o   (phase),
      .done_o    (done)
   );

   always_comb begin
      page_d  = trigger ? bus.cpu_wdata : page_q;
      latch_d = ((state == DMA_XFER) && (phase == PH_W'(1))) ? bus.mem_rdata : latch_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         page_q  <= 8'h00;
         latch_q <= 8'h00;
      end else begin
         page_q  <= page_d;
         latch_q <= latch_d;
      end
   end

   always_comb begin
      bus.cpu_rdata = OPEN_BUS;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.mem_re    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.hi_addr   = bus.cpu_addr[6:0];
      bus.hi_wdata  = bus.cpu_wdata;
      bus.hi_re     = 1'b0;
      bus.hi_we     = 1'b0;

      // Strobes are held low combinationally while reset is asserted, not just after the next edge.
      if (rst) begin
         bus.hi_re = bus.cpu_re && hram_hit;
         bus.hi_we = bus.cpu_we && hram_hit;

         if (hram_hit) begin
            bus.cpu_rdata = bus.hi_rdata;
         end else if (reg_hit) begin
            bus.cpu_rdata = page_q;
         end else if (state == DMA_IDLE) begin
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
            bus.mem_re    = bus.cpu_re;
            bus.mem_we    = bus.cpu_we;
            bus.cpu_rdata = bus.mem_rdata;
         end

         if (state == DMA_XFER) begin
            if (phase == PH_W'(0)) begin
               bus.mem_re   = 1'b1;
               bus.mem_addr = {source_page(page_q), slot};
            end else if (phase == PH_W'(2)) begin
               bus.mem_we    = 1'b1;
               bus.mem_addr  = OAM_BASE + {8'h00, slot};
               bus.mem_wdata = latch_q;
            end
         end
      end
   end

   assign bus.dma_active = (state != DMA_IDLE);
   assign bus.dma_done   = done;

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Self-checking bench for oam_dma_arbiter: randomized memory contents and pages against a timeline model.
module tb_oam_dma_arbiter;

   typedef struct {
      int          n;
      logic [15:0] addr;
      logic [7:0]  data;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   oam_dma_arbiter_if bus_if ();

   oam_dma_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] mem [65536];
   bit         mem_valid [65536];
   logic [7:0] seed8;

   ev_t re_q[$], we_q[$], exp_re[$], exp_we[$];
   int  done_q[$];
   int  trig_n[$];
   logic [7:0] trig_pg[$];
   int  act_cnt, first_act;

   // Unwritten locations read back a seeded hash of their address.
   function automatic logic [7:0] mem_read(input logic [15:0] a);
      return mem_valid[a] ? mem[a] : ((a[7:0] * 8'd29) ^ a[15:8] ^ seed8);
   endfunction

   always @(posedge clk) begin
      if (bus_if.mem_we) begin
         mem[bus_if.mem_addr]       <= bus_if.mem_wdata;
         mem_valid[bus_if.mem_addr] <= 1'b1;
      end
      if (bus_if.mem_re) bus_if.mem_rdata <= mem_read(bus_if.mem_addr);
   end

   function automatic logic [7:0] model_src(input logic [7:0] p);
`ifdef DMA_ECHO_MAP_EN
      if (p >= 8'hE0) return p - 8'h20;
`endif
      return p;
   endfunction

   function automatic int first_diff(input ev_t a[$], input ev_t b[$]);
      if (a.size() != b.size()) return (a.size() < b.size()) ? a.size() : b.size();
      foreach (a[i])
         if (a[i].n != b[i].n || a[i].addr !== b[i].addr || a[i].data !== b[i].data) return i;
      return -1;
   endfunction

   task automatic drive_idle();
      bus_if.cpu_addr = 16'h0000; bus_if.cpu_wdata = 8'h00;
      bus_if.cpu_re = 1'b0; bus_if.cpu_we = 1'b0;
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
      bus_if.cpu_addr = a; bus_if.cpu_wdata = d; bus_if.cpu_re = 1'b0; bus_if.cpu_we = 1'b1;
   endtask

   task automatic cpu_read(input logic [15:0] a);
      bus_if.cpu_addr = a; bus_if.cpu_wdata = 8'h00; bus_if.cpu_re = 1'b1; bus_if.cpu_we = 1'b0;
   endtask

   // Trigger write sampled at n=-1, optional restart write at n=rn; records bus activity per sample.
   task automatic run_dma(input logic [7:0] p0, input int rn, input logic [7:0] p1, input int max_n);
      re_q.delete(); we_q.delete(); done_q.delete(); trig_n.delete(); trig_pg.delete();
      act_cnt = 0; first_act = -99;
      trig_n.push_back(-1); trig_pg.push_back(p0);
      if (rn >= 0) begin trig_n.push_back(rn); trig_pg.push_back(p1); end
      for (int n = -1; n < max_n; n++) begin
         @(negedge clk);
         if (n == -1) cpu_write(16'hFF46, p0);
         else if (n == rn) cpu_write(16'hFF46, p1);
         else drive_idle();
         #1;
         if (bus_if.mem_re) re_q.push_back('{n, bus_if.mem_addr, 8'h00});
         if (bus_if.mem_we) we_q.push_back('{n, bus_if.mem_addr, bus_if.mem_wdata});
         if (bus_if.dma_done) done_q.push_back(n);
         if (bus_if.dma_active) begin
            act_cnt++;
            if (first_act == -99) first_act = n;
         end
      end
      drive_idle();
   endtask

   // Each trigger at sample t0 starts a 4-clock startup; slot k reads at t0+5+4k, writes at t0+7+4k.
   task automatic build_expected(output int done_n, output int act_n);
      exp_re.delete(); exp_we.delete();
      foreach (trig_n[i]) begin
         int t0 = trig_n[i];
         int lim = (i + 1 < trig_n.size()) ? trig_n[i + 1] : 32'h7FFF_FFFF;
         logic [7:0] sp = model_src(trig_pg[i]);
         for (int k = 0; k < 160; k++) begin
            if (t0 + 5 + 4 * k <= lim) exp_re.push_back('{t0 + 5 + 4 * k, {sp, 8'(k)}, 8'h00});
            if (t0 + 7 + 4 * k <= lim)
               exp_we.push_back('{t0 + 7 + 4 * k, 16'hFE00 + 16'(k), mem_read({sp, 8'(k)})});
         end
      end
      done_n = trig_n[trig_n.size() - 1] + 645;
      act_n  = done_n - trig_n[0] - 1;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int waited = 0;
      drive_idle();
      while (waited < budget) begin
         @(negedge clk); #1;
         if (!bus_if.dma_active) break;
         waited++;
      end
      n_checks++;
      if (waited >= budget) begin
         n_fail++;
         $display("FAIL %s_idle_timeout: still active after %0d clocks, required idle", name, budget);
      end
   endtask

   task automatic test_reset();
      #1 rst = 1'b0;
      cpu_write(16'h1234, 8'hA5);
      bus_if.cpu_re = 1'b1; bus_if.hi_rdata = 8'h00;
      #2;
      n_checks++;
      if ({bus_if.mem_re, bus_if.mem_we, bus_if.hi_re, bus_if.hi_we, bus_if.dma_active,
           bus_if.dma_done, bus_if.mem_addr, bus_if.mem_wdata} !== 30'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got re=%b we=%b hre=%b hwe=%b act=%b done=%b addr=%h wd=%h, required all 0",
                  bus_if.mem_re, bus_if.mem_we, bus_if.hi_re, bus_if.hi_we, bus_if.dma_active,
                  bus_if.dma_done, bus_if.mem_addr, bus_if.mem_wdata);
      end
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b1; cpu_read(16'hFF46);
      #1;
      n_checks++;
      if (bus_if.cpu_rdata !== 8'h00) begin
         n_fail++; $display("FAIL reset_page: got %h required 00", bus_if.cpu_rdata);
      end
      drive_idle();
   endtask

   task automatic test_idle_passthrough();
      logic [15:0] a = 16'($urandom_range(0, 16'hFEFF));
      logic [15:0] wa = 16'($urandom_range(0, 16'h7FFF));
      logic [7:0]  wd = 8'($urandom);
      @(negedge clk); cpu_read(a); #1;
      n_checks++;
      if (bus_if.mem_re !== 1'b1 || bus_if.mem_addr !== a) begin
         n_fail++; $display("FAIL idle_read_fwd: got re=%b addr=%h required re=1 addr=%h", bus_if.mem_re, bus_if.mem_addr, a);
      end
      @(negedge clk); #1;
      n_checks++;
      if (bus_if.cpu_rdata !== mem_read(a)) begin
         n_fail++; $display("FAIL idle_read_data: got %h required %h", bus_if.cpu_rdata, mem_read(a));
      end
      @(negedge clk); cpu_write(wa, wd); #1;
      n_checks++;
      if (bus_if.mem_we !== 1'b1 || bus_if.mem_addr !== wa || bus_if.mem_wdata !== wd || bus_if.hi_we !== 1'b0) begin
         n_fail++; $display("FAIL idle_write_fwd: got we=%b addr=%h data=%h required we=1 addr=%h data=%h",
                            bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata, wa, wd);
      end
      @(negedge clk); cpu_write(16'hFFA0, wd); #1;
      n_checks++;
      if (bus_if.hi_we !== 1'b1 || bus_if.hi_addr !== 7'h20 || bus_if.hi_wdata !== wd || bus_if.mem_we !== 1'b0) begin
         n_fail++; $display("FAIL idle_hram_write: got hwe=%b haddr=%h mwe=%b required hwe=1 haddr=20 mwe=0",
                            bus_if.hi_we, bus_if.hi_addr, bus_if.mem_we);
      end
      drive_idle();
   endtask

   task automatic test_full_transfer();
      int done_n, act_n, d, oam_bad;
      run_dma(8'hC1, -2, 8'h00, 660);
      build_expected(done_n, act_n);
      n_checks++;
      if (first_act !== 0) begin n_fail++; $display("FAIL full_active_rise: got sample %0d required 0", first_act); end
      n_checks++;
      if (re_q.size() == 0 || re_q[0].n != 4 || re_q[0].addr !== 16'hC100) begin
         n_fail++; $display("FAIL full_first_read: got n=%0d addr=%h required n=4 addr=C100",
                            (re_q.size() > 0) ? re_q[0].n : -1, (re_q.size() > 0) ? re_q[0].addr : 16'hxxxx);
      end
      n_checks++;
      if (we_q.size() == 0 || we_q[0].addr !== 16'hFE00 || we_q[0].data !== mem_read(16'hC100)) begin
         n_fail++; $display("FAIL full_first_write: got addr=%h data=%h required FE00/%h",
                            (we_q.size() > 0) ? we_q[0].addr : 16'hxxxx, (we_q.size() > 0) ? we_q[0].data : 8'hxx, mem_read(16'hC100));
      end
      n_checks++;
      if (we_q.size() == 0 || we_q[we_q.size() - 1].addr !== 16'hFE9F) begin
         n_fail++; $display("FAIL full_last_write: got %h required FE9F", (we_q.size() > 0) ? we_q[we_q.size() - 1].addr : 16'hxxxx);
      end
      d = first_diff(re_q, exp_re); n_checks++;
      if (d != -1) begin n_fail++; $display("FAIL full_reads: diverge at %0d, got %0d reads required %0d", d, re_q.size(), exp_re.size()); end
      d = first_diff(we_q, exp_we); n_checks++;
      if (d != -1) begin n_fail++; $display("FAIL full_writes: diverge at %0d, got %0d writes required %0d", d, we_q.size(), exp_we.size()); end
      n_checks++;
      if (done_q.size() != 1 || done_q[0] != done_n) begin
         n_fail++; $display("FAIL full_done: got %0d pulses first at %0d required 1 at %0d", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, done_n);
      end
      n_checks++;
      if (act_cnt != act_n) begin n_fail++; $display("FAIL full_active_len: got %0d required %0d", act_cnt, act_n); end
      oam_bad = 0;
      for (int k = 0; k < 160; k++) if (mem_read(16'hFE00 + 16'(k)) !== mem_read({8'hC1, 8'(k)})) oam_bad++;
      n_checks++;
      if (oam_bad != 0) begin n_fail++; $display("FAIL full_oam_contents: got %0d wrong bytes required 0", oam_bad); end
   endtask

   task automatic test_cpu_during_dma();
      int hi_bad = 0, rd_bad = 0, bus_bad = 0;
      logic [7:0] hd;
      @(negedge clk); cpu_write(16'hFF46, 8'hC1);
      for (int n = 0; n < 120; n++) begin
         int op = $urandom_range(0, 3);
         bit er = (n >= 4) && ((n - 4) % 4 == 0);
         bit ew = (n >= 4) && ((n - 4) % 4 == 2);
         logic [7:0] slot = 8'((n - 4) / 4);
         @(negedge clk);
         hd = 8'($urandom);
         if (n == 10) begin op = 0; hd = 8'h55; end
         if (n == 12) op = 4;
         if (n == 13) op = 5;
         bus_if.hi_rdata = hd;
         case (op)
            0: cpu_read(16'($urandom_range(16'hFF80, 16'hFFFE)));
            1: cpu_read(16'($urandom_range(0, 16'hFEFF)));
            2: cpu_write(16'($urandom_range(0, 16'hFEFF)), 8'($urandom));
            4: cpu_read(16'hC000);
            5: cpu_write(16'hD000, 8'h3C);
            default: drive_idle();
         endcase
         #1;
         if (op == 0 && (bus_if.cpu_rdata !== hd || bus_if.hi_re !== 1'b1)) hi_bad++;
         if ((op == 1 || op == 4) && bus_if.cpu_rdata !== 8'hFF) rd_bad++;
         if (bus_if.mem_re !== er || bus_if.mem_we !== ew ||
             (er && bus_if.mem_addr !== {8'hC1, slot}) || (ew && bus_if.mem_addr !== 16'hFE00 + {8'h00, slot}))
            bus_bad++;
         if (n == 10) begin
            n_checks++;
            if (bus_if.cpu_rdata !== 8'h55 || bus_if.hi_re !== 1'b1) begin
               n_fail++; $display("FAIL dma_hram_read: got data=%h hre=%b required 55/1", bus_if.cpu_rdata, bus_if.hi_re);
            end
         end
         if (n == 12) begin
            n_checks++;
            if (bus_if.cpu_rdata !== 8'hFF || bus_if.mem_addr !== 16'hC102) begin
               n_fail++; $display("FAIL dma_blocked_read: got data=%h addr=%h required FF/C102", bus_if.cpu_rdata, bus_if.mem_addr);
            end
         end
         if (n == 13) begin
            n_checks++;
            if (bus_if.mem_we !== 1'b0) begin n_fail++; $display("FAIL dma_blocked_write: got mem_we=%b required 0", bus_if.mem_we); end
         end
      end
      n_checks++;
      if (hi_bad != 0) begin n_fail++; $display("FAIL dma_hram_random: got %0d bad samples required 0", hi_bad); end
      n_checks++;
      if (rd_bad != 0) begin n_fail++; $display("FAIL dma_open_bus_random: got %0d bad samples required 0", rd_bad); end
      n_checks++;
      if (bus_bad != 0) begin n_fail++; $display("FAIL dma_bus_ownership: got %0d bad samples required 0", bus_bad); end
      wait_idle("cpu_dma", 700);
   endtask

   task automatic test_restart(input string name, input int rn, input logic [7:0] p1);
      int done_n, act_n, d, oam_bad;
      logic [7:0] p0 = 8'($urandom_range(0, 8'hDF));
      run_dma(p0, rn, p1, rn + 660);
      build_expected(done_n, act_n);
      d = first_diff(re_q, exp_re); n_checks++;
      if (d != -1) begin n_fail++; $display("FAIL %s_reads: diverge at %0d, got %0d reads required %0d", name, d, re_q.size(), exp_re.size()); end
      d = first_diff(we_q, exp_we); n_checks++;
      if (d != -1) begin n_fail++; $display("FAIL %s_writes: diverge at %0d, got %0d writes required %0d", name, d, we_q.size(), exp_we.size()); end
      n_checks++;
      if (done_q.size() != 1 || done_q[0] != done_n) begin
         n_fail++; $display("FAIL %s_done: got %0d pulses first at %0d required 1 at %0d", name, done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, done_n);
      end
      n_checks++;
      if (act_cnt != act_n) begin n_fail++; $display("FAIL %s_active_len: got %0d required %0d", name, act_cnt, act_n); end
      oam_bad = 0;
      for (int k = 0; k < 160; k++) if (mem_read(16'hFE00 + 16'(k)) !== mem_read({model_src(p1), 8'(k)})) oam_bad++;
      n_checks++;
      if (oam_bad != 0) begin n_fail++; $display("FAIL %s_oam_contents: got %0d wrong bytes required 0", name, oam_bad); end
   endtask

   task automatic test_dma_reg();
      int bad = 0;
      @(negedge clk); cpu_write(16'hFF46, 8'h80); #1;
      n_checks++;
      if (bus_if.mem_we !== 1'b0 || bus_if.hi_we !== 1'b0) begin
         n_fail++; $display("FAIL reg_write_local: got mem_we=%b hi_we=%b required 0/0", bus_if.mem_we, bus_if.hi_we);
      end
      @(negedge clk); cpu_read(16'hFF46); #1;
      n_checks++;
      if (bus_if.cpu_rdata !== 8'h80 || bus_if.mem_re !== 1'b0) begin
         n_fail++; $display("FAIL reg_readback: got data=%h mem_re=%b required 80/0", bus_if.cpu_rdata, bus_if.mem_re);
      end
      drive_idle();
      for (int n = 0; n < 700 && bus_if.dma_active; n++) begin
         @(negedge clk); #1;
         if (bus_if.mem_we && bus_if.mem_addr == 16'hFF46) bad++;
      end
      n_checks++;
      if (bad != 0 || bus_if.dma_active) begin
         n_fail++; $display("FAIL reg_no_bus_write: got %0d writes to FF46 active=%b required 0/0", bad, bus_if.dma_active);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk); cpu_write(16'hFF46, 8'($urandom_range(0, 8'hDF)));
      for (int n = 0; n <= 404; n++) begin @(negedge clk); drive_idle(); end
      cpu_read(16'hFF90);
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if ({bus_if.mem_re, bus_if.mem_we, bus_if.hi_re, bus_if.hi_we, bus_if.dma_active, bus_if.mem_addr} !== 21'h0) begin
         n_fail++; $display("FAIL midreset_async: got re=%b we=%b hre=%b hwe=%b act=%b addr=%h required all 0",
                            bus_if.mem_re, bus_if.mem_we, bus_if.hi_re, bus_if.hi_we, bus_if.dma_active, bus_if.mem_addr);
      end
      @(negedge clk); rst = 1'b1; cpu_read(16'h0100); #1;
      n_checks++;
      if (bus_if.mem_re !== 1'b1 || bus_if.mem_addr !== 16'h0100 || bus_if.dma_active !== 1'b0) begin
         n_fail++; $display("FAIL midreset_passthrough: got re=%b addr=%h act=%b required 1/0100/0",
                            bus_if.mem_re, bus_if.mem_addr, bus_if.dma_active);
      end
      @(negedge clk); #1;
      n_checks++;
      if (bus_if.cpu_rdata !== mem_read(16'h0100)) begin
         n_fail++; $display("FAIL midreset_read_data: got %h required %h", bus_if.cpu_rdata, mem_read(16'h0100));
      end
      drive_idle();
   endtask

   task automatic test_echo();
      int done_n, act_n, d;
      logic [15:0] first_src = {model_src(8'hE2), 8'h00};
      run_dma(8'hE2, -2, 8'h00, 660);
      build_expected(done_n, act_n);
      n_checks++;
      if (re_q.size() == 0 || re_q[0].addr !== first_src) begin
         n_fail++; $display("FAIL echo_first_read: got %h required %h", (re_q.size() > 0) ? re_q[0].addr : 16'hxxxx, first_src);
      end
      d = first_diff(we_q, exp_we); n_checks++;
      if (d != -1) begin n_fail++; $display("FAIL echo_writes: diverge at %0d, got %0d writes required %0d", d, we_q.size(), exp_we.size()); end
      @(negedge clk); cpu_read(16'hFF46); #1;
      n_checks++;
      if (bus_if.cpu_rdata !== 8'hE2) begin n_fail++; $display("FAIL echo_readback: got %h required E2", bus_if.cpu_rdata); end
      drive_idle();
   endtask

   initial begin
      seed8 = 8'($urandom);
      bus_if.hi_rdata = 8'h00;
      drive_idle();
      test_reset();
      test_idle_passthrough();
      test_full_transfer();
      test_cpu_during_dma();
      test_restart("restart_slot50", 204, 8'hD0);
      test_restart("restart_final", 643, 8'($urandom_range(0, 8'hDF)));
      test_dma_reg();
      test_reset_mid();
      test_echo();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
